// File: rtl/yblock_wb_port_if.sv
// Wishbone classic slave bus bundle for the yblock port.
// The master modport is the bus side and the slave modport is the register block side.
interface yblock_wb_port_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/yblock_wb_port.sv
// Wishbone register port for a yblock cell: a configuration clock pulse generator
// and an edge-data path that captures the cell outputs after a fixed settle time.
module yblock_wb_port #(
  parameter logic [31:0] BASE_ADR = 32'h3000_0000,
  parameter int unsigned PULSE_W  = 4,
  parameter int unsigned SETTLE   = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  yblock_wb_port_if.slave        wb,
  output logic                   blk_reset,
  output logic                   blk_confclk,
  output logic [15:0]            blk_cfg,
  output logic [31:0]            blk_din,
  input  logic [15:0]            blk_cout,
  input  logic [31:0]            blk_dout
);

  localparam logic [2:0] OFF_CTRL    = 3'd0;
  localparam logic [2:0] OFF_CFG     = 3'd1;
  localparam logic [2:0] OFF_DIN     = 3'd2;
  localparam logic [2:0] OFF_STATUS  = 3'd3;
  localparam logic [2:0] OFF_DOUT_LO = 3'd4;
  localparam logic [2:0] OFF_DOUT_HI = 3'd5;

  localparam logic [7:0] PHASE_LAST = 8'(PULSE_W - 1);
  localparam logic [7:0] SETTLE_LD  = 8'(SETTLE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_HOLD  = 2'd3
  } cfg_state_e;

  cfg_state_e  state_q, state_d;
  logic [7:0]  phase_q, phase_d;
  logic        confclk_q, confclk_d;
  logic [15:0] cfg_q, cfg_d;
  logic        reset_q, reset_d;
  logic [31:0] din_q, din_d;
  logic [7:0]  settle_q, settle_d;
  logic        valid_q, valid_d;
  logic [31:0] dout_lo_q, dout_lo_d;
  logic [15:0] dout_hi_q, dout_hi_d;
  logic        ack_q, ack_d;
  logic [31:0] dat_o_q, dat_o_d;
  logic        wr_q, wr_d;
  logic [2:0]  wr_off_q, wr_off_d;
  logic [31:0] wr_dat_q, wr_dat_d;

  logic        hit, stall, busy, capture;
  logic [2:0]  req_off;
  logic [31:0] rd_data;
  logic        ctrl_wr, cfg_wr, din_wr;
  logic        unused_bits;

  assign unused_bits = ^{wb.wbs_sel_i, wb.wbs_adr_i[7:5], wb.wbs_adr_i[1:0]};
  assign busy        = (state_q != S_IDLE);
  assign req_off     = wb.wbs_adr_i[4:2];

  // A request is acked in the cycle after it is seen; gating on ack_q forces
  // a dead cycle between transfers. A CFG write is held off until the pulse ends.
  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin : bus_front
    hit      = 1'b0;
    stall    = 1'b0;
    ack_d    = 1'b0;
    wr_d     = 1'b0;
    wr_off_d = req_off;
    wr_dat_d = wb.wbs_dat_i;
    dat_o_d  = '0;
    hit   = wb.wbs_stb_i && wb.wbs_cyc_i && !ack_q &&
            (wb.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    stall = wb.wbs_we_i && (req_off == OFF_CFG) && busy;
    ack_d = hit && !stall;
    wr_d  = ack_d && wb.wbs_we_i;
    if (ack_d && !wb.wbs_we_i) dat_o_d = rd_data;
  end

  always_comb begin : read_mux
    rd_data = '0;
    case (req_off)
      OFF_CTRL:    rd_data = {31'b0, reset_q};
      OFF_DIN:     rd_data = din_q;
      OFF_STATUS:  rd_data = {30'b0, valid_q, busy};
      OFF_DOUT_LO: rd_data = dout_lo_q;
      OFF_DOUT_HI: rd_data = {16'b0, dout_hi_q};
      default:     rd_data = '0;
    endcase
  end

  // Writes take effect on the edge after their ack cycle.
  assign ctrl_wr = wr_q && (wr_off_q == OFF_CTRL);
  assign cfg_wr  = wr_q && (wr_off_q == OFF_CFG);
  assign din_wr  = wr_q && (wr_off_q == OFF_DIN);

  always_comb begin : cfg_fsm
    state_d   = state_q;
    phase_d   = phase_q;
    cfg_d     = cfg_q;
    confclk_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_wr) begin
          state_d = S_SETUP;
          phase_d = PHASE_LAST;
          cfg_d   = wr_dat_q[15:0];
        end
      end
      default: begin
        if (phase_q == 8'd0) begin
          phase_d = PHASE_LAST;
          case (state_q)
            S_SETUP: state_d = S_HIGH;
            S_HIGH:  state_d = S_HOLD;
            default: state_d = S_IDLE;
          endcase
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end
    endcase
    confclk_d = (state_d == S_HIGH);
  end

  // The cell outputs are sampled only once the settle window has elapsed, when
  // they are quiescent; a restart by a new DIN write suppresses that capture.
  always_comb begin : data_path
    reset_d   = reset_q;
    din_d     = din_q;
    settle_d  = settle_q;
    valid_d   = valid_q;
    dout_lo_d = dout_lo_q;
    dout_hi_d = dout_hi_q;
    capture   = 1'b0;
    if (ctrl_wr) reset_d = wr_dat_q[0];
    if (din_wr) begin
      din_d    = wr_dat_q;
      settle_d = SETTLE_LD;
    end else if (settle_q != 8'd0) begin
      settle_d = settle_q - 8'd1;
      capture  = (settle_q == 8'd1);
    end
    if (capture) begin
      dout_lo_d = blk_dout;
      dout_hi_d = blk_cout;
      valid_d   = 1'b1;
    end
    if (din_wr || cfg_wr || (ctrl_wr && wr_dat_q[0])) valid_d = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      confclk_q <= 1'b0;
      cfg_q     <= '0;
      reset_q   <= 1'b1;
      din_q     <= '0;
      settle_q  <= '0;
      valid_q   <= 1'b0;
      dout_lo_q <= '0;
      dout_hi_q <= '0;
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      wr_q      <= 1'b0;
      wr_off_q  <= '0;
      wr_dat_q  <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      confclk_q <= confclk_d;
      cfg_q     <= cfg_d;
      reset_q   <= reset_d;
      din_q     <= din_d;
      settle_q  <= settle_d;
      valid_q   <= valid_d;
      dout_lo_q <= dout_lo_d;
      dout_hi_q <= dout_hi_d;
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      wr_q      <= wr_d;
      wr_off_q  <= wr_off_d;
      wr_dat_q  <= wr_dat_d;
    end
  end

  assign wb.wbs_ack_o = ack_q;
  assign wb.wbs_dat_o = dat_o_q;
  assign blk_reset    = reset_q;
  assign blk_confclk  = confclk_q;
  assign blk_cfg      = cfg_q;
  assign blk_din      = din_q;

endmodule

// File: tb/tb_yblock_wb_port.sv
// Bench for yblock_wb_port: register table after reset, directed pulse/settle/reset
// sequences, then random traffic against a timeline model of the data path.
module tb_yblock_wb_port;

  localparam logic [31:0] BASE    = 32'h3000_0000;
  localparam int          PULSE_W = 4;
  localparam int          SETTLE  = 8;
  localparam int          HIST    = 8192;

  logic        clk = 1'b0;
  logic        rst;
  logic        blk_reset, blk_confclk;
  logic [15:0] blk_cfg, blk_cout;
  logic [31:0] blk_din, blk_dout;

  yblock_wb_port_if wb ();

  yblock_wb_port #(.BASE_ADR(BASE), .PULSE_W(PULSE_W), .SETTLE(SETTLE)) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb         (wb),
    .blk_reset  (blk_reset),
    .blk_confclk(blk_confclk),
    .blk_cfg    (blk_cfg),
    .blk_din    (blk_din),
    .blk_cout   (blk_cout),
    .blk_dout   (blk_dout)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_cnt  = 0;
  logic        cc_hist   [HIST];
  logic [15:0] cfg_hist  [HIST];
  logic [31:0] dout_hist [HIST];
  logic [15:0] cout_hist [HIST];

  // Edge numbering: edge N is the N-th rising edge; the values sampled there are logged.
  always @(posedge clk) begin
    cyc_cnt = cyc_cnt + 1;
    dout_hist[cyc_cnt % HIST] = blk_dout;
    cout_hist[cyc_cnt % HIST] = blk_cout;
  end

  always @(negedge clk) begin
    cc_hist[cyc_cnt % HIST]  = blk_confclk;
    cfg_hist[cyc_cnt % HIST] = blk_cfg;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc_cnt < t) @(negedge clk);
  endtask

  // One classic transfer; r_cyc is the cycle the request is presented, a_cyc the ack cycle.
  task automatic bus(input bit we, input logic [2:0] off, input logic [31:0] dat,
                     output logic [31:0] rd, output int r_cyc, output int a_cyc);
    int waits;
    @(negedge clk);
    wb.wbs_stb_i = 1'b1;
    wb.wbs_cyc_i = 1'b1;
    wb.wbs_we_i  = we;
    wb.wbs_sel_i = 4'hF;
    wb.wbs_adr_i = BASE | {27'b0, off, 2'b00};
    wb.wbs_dat_i = dat;
    r_cyc = cyc_cnt;
    waits = 0;
    @(negedge clk);
    while (wb.wbs_ack_o !== 1'b1 && waits < 100) begin
      @(negedge clk);
      waits++;
    end
    check("ack_seen", {31'b0, wb.wbs_ack_o}, 32'd1);
    a_cyc = cyc_cnt;
    rd    = wb.wbs_dat_o;
    wb.wbs_stb_i = 1'b0;
    wb.wbs_cyc_i = 1'b0;
    wb.wbs_we_i  = 1'b0;
    @(negedge clk);
    check("ack_gap", {31'b0, wb.wbs_ack_o}, 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  off;
    logic [31:0] wdat;
    logic [31:0] exp_rd;
    logic        exp_rst;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  // Reference model of the data path: event times derived from the ack cycle.
  logic [31:0] m_din, m_lo;
  logic [15:0] m_hi;
  logic        m_valid, m_rst;
  int          m_pend;

  task automatic advance(input int t);
    if (m_pend >= 0 && m_pend <= t) begin
      m_lo    = dout_hist[m_pend % HIST];
      m_hi    = cout_hist[m_pend % HIST];
      m_valid = 1'b1;
      m_pend  = -1;
    end
  endtask

  initial begin
    logic [31:0] rd, d, act_v, exp_v;
    int r, a, c1, c2, acks, bad, op;

    rst = 1'b1;
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0;  wb.wbs_dat_i = '0;
    blk_dout = '0; blk_cout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_dat_o", wb.wbs_dat_o, 32'd0);
    check("rst_blk_reset", {31'b0, blk_reset}, 32'd1);
    check("rst_confclk", {31'b0, blk_confclk}, 32'd0);
    check("rst_cfg", {16'b0, blk_cfg}, 32'd0);
    check("rst_din", blk_din, 32'd0);
    rst = 1'b0;

    // Register map table: {we, offset, wdata, expected read, expected blk_reset}
    tbl[0]  = '{1'b0, 3'd0, 32'h0,        32'h1, 1'b1};
    tbl[1]  = '{1'b0, 3'd3, 32'h0,        32'h0, 1'b1};
    tbl[2]  = '{1'b0, 3'd4, 32'h0,        32'h0, 1'b1};
    tbl[3]  = '{1'b0, 3'd5, 32'h0,        32'h0, 1'b1};
    tbl[4]  = '{1'b0, 3'd2, 32'h0,        32'h0, 1'b1};
    tbl[5]  = '{1'b0, 3'd1, 32'h0,        32'h0, 1'b1};
    tbl[6]  = '{1'b0, 3'd6, 32'h0,        32'h0, 1'b1};
    tbl[7]  = '{1'b0, 3'd7, 32'h0,        32'h0, 1'b1};
    tbl[8]  = '{1'b1, 3'd0, 32'hFFFF_FFFE, 32'h0, 1'b0};
    tbl[9]  = '{1'b0, 3'd0, 32'h0,        32'h0, 1'b0};
    tbl[10] = '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[11] = '{1'b0, 3'd0, 32'h0,        32'h1, 1'b1};
    tbl[12] = '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 3'd7, 32'h0,        32'h0, 1'b1};
    tbl[14] = '{1'b1, 3'd3, 32'hFFFF_FFFF, 32'h0, 1'b1};
    tbl[15] = '{1'b0, 3'd3, 32'h0,        32'h0, 1'b1};
    tbl[16] = '{1'b1, 3'd0, 32'h0,        32'h0, 1'b0};
    tbl[17] = '{1'b0, 3'd0, 32'h0,        32'h0, 1'b0};
    for (int i = 0; i < NV; i++) begin
      bus(tbl[i].we, tbl[i].off, tbl[i].wdat, rd, r, a);
      if (!tbl[i].we) check($sformatf("tbl%0d_rd", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_latency", i), 32'(a - r), 32'd1);
      check($sformatf("tbl%0d_blk_reset", i), {31'b0, blk_reset}, {31'b0, tbl[i].exp_rst});
    end

    // Address outside the decoded window is never acked.
    @(negedge clk);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_adr_i = BASE + 32'h100;
    acks = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) acks++;
    end
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
    check("undecoded_no_ack", 32'(acks), 32'd0);

    // Single configuration pulse.
    bus(1'b1, 3'd1, 32'hFFFF_A5C3, rd, r, c1);
    check("cfg_value", {16'b0, blk_cfg}, 32'h0000_A5C3);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("cfg_busy_mid", rd, 32'h1);
    wait_until(c1 + 24);
    act_v = '0; exp_v = '0; bad = 0;
    for (int k = 0; k < 20; k++) begin
      act_v[k] = cc_hist[(c1 + k) % HIST];
      exp_v[k] = (k >= 5 && k < 5 + PULSE_W);
    end
    for (int k = 1; k <= 3 * PULSE_W; k++)
      if (cfg_hist[(c1 + k) % HIST] !== 16'hA5C3) bad++;
    check("cfg_confclk_window", act_v, exp_v);
    check("cfg_stable", 32'(bad), 32'd0);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("cfg_idle_after", rd, 32'h0);

    // Two back-to-back writes: the second is stalled until the first pulse ends.
    bus(1'b1, 3'd1, 32'h0000_0001, rd, r, c1);
    bus(1'b1, 3'd1, 32'h0000_0002, rd, r, c2);
    check("cfg_stall_ack", 32'(c2), 32'(c1 + 3 * PULSE_W + 2));
    wait_until(c1 + 40);
    act_v = '0; exp_v = '0;
    for (int k = 0; k < 32; k++) begin
      act_v[k] = cc_hist[(c1 + k) % HIST];
      exp_v[k] = (k >= 5 && k < 5 + PULSE_W) ||
                 (k >= 3 * PULSE_W + 7 && k < 4 * PULSE_W + 7);
    end
    check("cfg_two_pulses", act_v, exp_v);
    check("cfg_first_hold", {16'b0, cfg_hist[(c1 + 3 * PULSE_W) % HIST]}, 32'h1);
    check("cfg_second_load", {16'b0, cfg_hist[(c2 + 1) % HIST]}, 32'h2);

    // DIN write and settle capture, probing just before and after completion.
    blk_dout = 32'h1234_5678; blk_cout = 16'h9ABC;
    bus(1'b1, 3'd2, 32'hDEAD_BEEF, rd, r, c1);
    check("din_drive", blk_din, 32'hDEAD_BEEF);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("din_valid_early", rd, 32'h0);
    wait_until(c1 + SETTLE - 1);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("din_valid_edge_before", rd, 32'h0);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("din_valid_set", rd, 32'h2);
    bus(1'b0, 3'd4, 32'h0, rd, r, a);
    check("din_dout_lo", rd, 32'h1234_5678);
    bus(1'b0, 3'd5, 32'h0, rd, r, a);
    check("din_dout_hi", rd, 32'h0000_9ABC);

    // Second DIN write mid-settle restarts the count; capture uses the later blk_dout.
    blk_dout = 32'h1111_1111; blk_cout = 16'h1111;
    bus(1'b1, 3'd2, 32'h0000_0001, rd, r, c1);
    wait_until(c1 + 3);
    bus(1'b1, 3'd2, 32'h0000_0002, rd, r, c2);
    blk_dout = 32'h2222_2222; blk_cout = 16'h5555;
    wait_until(c1 + SETTLE + 1);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("restart_no_early_valid", rd, 32'h0);
    bus(1'b0, 3'd4, 32'h0, rd, r, a);
    check("restart_dout_unchanged", rd, 32'h1234_5678);
    wait_until(c2 + SETTLE + 1);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("restart_valid", rd, 32'h2);
    bus(1'b0, 3'd4, 32'h0, rd, r, a);
    check("restart_dout_lo", rd, 32'h2222_2222);
    bus(1'b0, 3'd5, 32'h0, rd, r, a);
    check("restart_dout_hi", rd, 32'h0000_5555);

    // Settle completion on the same edge a CFG write is accepted: capture, valid cleared.
    blk_dout = 32'h3333_3333; blk_cout = 16'h7777;
    bus(1'b1, 3'd2, 32'h0F0F_0F0F, rd, r, c1);
    wait_until(c1 + SETTLE - 2);
    bus(1'b1, 3'd1, 32'h0000_00AA, rd, r, a);
    check("coincide_ack_cycle", 32'(a), 32'(c1 + SETTLE));
    wait_until(a + 3 * PULSE_W + 2);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("coincide_valid_cleared", rd, 32'h0);
    bus(1'b0, 3'd4, 32'h0, rd, r, a);
    check("coincide_dout_lo", rd, 32'h3333_3333);
    bus(1'b0, 3'd5, 32'h0, rd, r, a);
    check("coincide_dout_hi", rd, 32'h0000_7777);

    // Reset during HIGH with a stalled CFG write pending.
    bus(1'b1, 3'd1, 32'h0000_1234, rd, r, c1);
    @(negedge clk);
    wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1; wb.wbs_we_i = 1'b1;
    wb.wbs_adr_i = BASE | 32'h4; wb.wbs_dat_i = 32'h0000_4321;
    acks = 0;
    while (cyc_cnt < c1 + 6) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) acks++;
    end
    check("rst_mid_confclk_high", {31'b0, blk_confclk}, 32'd1);
    rst = 1'b1;
    wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
    @(negedge clk);
    check("rst_mid_confclk_low", {31'b0, blk_confclk}, 32'd0);
    check("rst_mid_ack", {31'b0, wb.wbs_ack_o}, 32'd0);
    check("rst_mid_dat_o", wb.wbs_dat_o, 32'd0);
    check("rst_mid_blk_reset", {31'b0, blk_reset}, 32'd1);
    check("rst_mid_cfg", {16'b0, blk_cfg}, 32'd0);
    check("rst_mid_din", blk_din, 32'd0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (wb.wbs_ack_o === 1'b1) acks++;
    end
    check("rst_mid_stall_dropped", 32'(acks), 32'd0);
    bus(1'b0, 3'd0, 32'h0, rd, r, a);
    check("rst_mid_ctrl", rd, 32'h1);
    bus(1'b0, 3'd3, 32'h0, rd, r, a);
    check("rst_mid_status", rd, 32'h0);
    bus(1'b0, 3'd4, 32'h0, rd, r, a);
    check("rst_mid_dout_lo", rd, 32'h0);
    bus(1'b0, 3'd5, 32'h0, rd, r, a);
    check("rst_mid_dout_hi", rd, 32'h0);
    bus(1'b0, 3'd2, 32'h0, rd, r, a);
    check("rst_mid_din_rd", rd, 32'h0);

    // Random traffic on the data path against the timeline model.
    m_din = '0; m_lo = '0; m_hi = '0; m_valid = 1'b0; m_rst = 1'b1; m_pend = -1;
    for (int it = 0; it < 80; it++) begin
      op = int'($urandom_range(0, 7));
      case (op)
        0: begin
          blk_dout = $urandom; blk_cout = 16'($urandom);
          d = $urandom;
          bus(1'b1, 3'd2, d, rd, r, a);
          advance(a);
          m_pend = a + SETTLE + 1; m_valid = 1'b0; m_din = d;
          check("rnd_blk_din", blk_din, m_din);
        end
        1: begin
          blk_dout = $urandom; blk_cout = 16'($urandom);
          repeat ($urandom_range(0, 10)) @(negedge clk);
        end
        2: begin
          bus(1'b0, 3'd3, 32'h0, rd, r, a); advance(r);
          check("rnd_status", rd, {30'b0, m_valid, 1'b0});
        end
        3: begin
          bus(1'b0, 3'd4, 32'h0, rd, r, a); advance(r);
          check("rnd_dout_lo", rd, m_lo);
        end
        4: begin
          bus(1'b0, 3'd5, 32'h0, rd, r, a); advance(r);
          check("rnd_dout_hi", rd, {16'b0, m_hi});
        end
        5: begin
          bus(1'b0, 3'd2, 32'h0, rd, r, a); advance(r);
          check("rnd_din_rd", rd, m_din);
        end
        6: begin
          d = $urandom;
          bus(1'b1, 3'd0, d, rd, r, a);
          advance(a + 1);
          m_rst = d[0];
          if (d[0]) m_valid = 1'b0;
          check("rnd_blk_reset", {31'b0, blk_reset}, {31'b0, m_rst});
        end
        default: begin
          bus(1'b0, 3'd0, 32'h0, rd, r, a); advance(r);
          check("rnd_ctrl", rd, {31'b0, m_rst});
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/yblock_wb_port.md
YBLOCK_WB_PORT -- requirements
Module: yblock_wb_port

Interface
- REQ-001 SHALL have parameter BASE_ADR, default 32'h3000_0000; the block decodes wbs_adr_i[31:8] == BASE_ADR[31:8].
- REQ-002 SHALL have parameter PULSE_W, default 4; cycles per phase of a configuration clock pulse, legal range 1..255.
- REQ-003 SHALL have parameter SETTLE, default 8; cycles from a DIN write to output capture, legal range 1..255.
- REQ-004 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-005 SHALL have port wb_rst_i, input, 1 bit: reset, synchronous and active-high.
- REQ-006 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i, input, 1 bit each: Wishbone classic slave strobe, cycle and write-enable.
- REQ-007 SHALL have port wbs_sel_i, input, 4 bits: ignored; every write is full-word.
- REQ-008 SHALL have ports wbs_adr_i and wbs_dat_i, input, 32 bits each: byte address and write data.
- REQ-009 SHALL have port wbs_ack_o, output, 1 bit: transfer acknowledge.
- REQ-010 SHALL have port wbs_dat_o, output, 32 bits: read data.
- REQ-011 SHALL have ports blk_reset and blk_confclk, output, 1 bit each: yblock cell reset and configuration clock.
- REQ-012 SHALL have port blk_cfg, output, 16 bits: yblock configuration data.
- REQ-013 SHALL have port blk_din, output, 32 bits: yblock edge data inputs.
- REQ-014 SHALL have ports blk_cout (16 bits) and blk_dout (32 bits), input: yblock configuration and data outputs, asynchronous to wb_clk_i.

Function
- REQ-015 SHALL decode registers by wbs_adr_i[4:2]: 0 CTRL (RW, bit0 = blk_reset), 1 CFG (W), 2 DIN (RW), 3 STATUS (RO: bit0 busy, bit1 valid), 4 DOUT_LO (RO, captured blk_dout), 5 DOUT_HI (RO, bits[15:0] = captured blk_cout).
- REQ-016 SHALL read unused bits and unmapped offsets as 0; writes to them SHALL have no effect but SHALL be acked.
- REQ-017 SHALL assert wbs_ack_o for exactly one cycle, in the cycle after a decoded stb&cyc, except when a CFG write is stalled (REQ-020).
- REQ-018 SHALL deassert wbs_ack_o for at least one cycle between consecutive transfers; wbs_dat_o SHALL be valid while ack=1.
- REQ-019 SHALL implement the config FSM IDLE -> SETUP -> HIGH -> HOLD -> IDLE, each non-IDLE state lasting PULSE_W cycles.
  - A CFG write accepted in IDLE loads blk_cfg = wbs_dat_i[15:0] and enters SETUP.
  - blk_confclk = 1 only in HIGH.
  - busy = (state != IDLE).
- REQ-020 SHALL withhold ack for a CFG write arriving while busy; ack SHALL follow in the cycle after IDLE is reached, and the write SHALL then start a new pulse.
- REQ-021 SHALL hold blk_cfg stable from SETUP entry until HOLD exit.
- REQ-022 SHALL respond to a DIN write by:
  - driving blk_din = wbs_dat_i from the next cycle,
  - clearing valid,
  - loading the settle counter with SETTLE.
- REQ-023 SHALL decrement the settle counter while nonzero; on the 1 -> 0 transition it SHALL latch blk_dout into DOUT_LO and blk_cout into DOUT_HI and set valid.
- REQ-024 SHALL restart the count and keep valid=0 when a DIN write occurs mid-settle; no intermediate capture is permitted.
- REQ-025 SHALL also clear valid on a CFG write acceptance and on a CTRL write setting bit0; these SHALL not touch the settle counter.
- REQ-026 SHALL make DOUT registers change only on capture, so reads are never torn.
- REQ-027 SHALL capture on schedule when settle completion and an accepted CFG write fall in the same cycle, and valid SHALL end 0 (clear wins).

Reset
- REQ-028 SHALL, on wb_rst_i=1 at a clock edge, set: FSM IDLE, blk_confclk=0, blk_reset=1, blk_cfg=0, blk_din=0, settle counter 0, valid=0, DOUT_LO/HI=0, wbs_ack_o=0, wbs_dat_o=0.
- REQ-029 SHALL apply reset mid-pulse in the same edge (blk_confclk=0 next cycle) and SHALL drop any pending stalled CFG write without ack.

Verification
- REQ-030 SHALL cover: reset, then read CTRL -> 0x1; read STATUS -> 0x0; read DOUT_LO -> 0x0.
- REQ-031 SHALL cover: CFG write 0xA5C3 with defaults -> blk_cfg=0xA5C3; blk_confclk high exactly 4 cycles starting 5 cycles after ack; busy=1 for 12 cycles.
- REQ-032 SHALL cover: two back-to-back CFG writes 0x0001, 0x0002 -> second ack delayed until first pulse ends; two full pulses observed, no overlap.
- REQ-033 SHALL cover: DIN write 0xDEADBEEF with blk_dout=0x12345678 and blk_cout=0x9ABC -> STATUS valid=1 after 8 cycles; DOUT_LO=0x12345678; DOUT_HI=0x00009ABC.
- REQ-034 SHALL cover: second DIN write at cycle 5 of settle -> valid stays 0 until 8 cycles after the second write; capture reflects blk_dout at that time.
- REQ-035 SHALL cover: wb_rst_i pulsed during HIGH -> blk_confclk=0 the next cycle; stalled CFG write never acked; all registers at REQ-028 values.
